// File: rtl/fir_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_ctrl_pkg
// Description : Shared state encoding and defaults for the FIR stream controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_ctrl_pkg;

    localparam int unsigned c_N_TAPS_DEFAULT  = 15;
    localparam int unsigned c_FIR_LAT_DEFAULT = 3;

    // A flush counts zero issues 0..N_TAPS-2, so $clog2(N_TAPS) bits suffice.
    function automatic int unsigned flush_cnt_width(input int unsigned n_taps);
        return (n_taps > 2) ? $clog2(n_taps) : 1;
    endfunction

    localparam int unsigned c_FLUSH_CNT_W = flush_cnt_width(c_N_TAPS_DEFAULT);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/fir_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_ctrl_fifo
// Description : Synchronous first-word-fall-through FIFO with occupancy count
//               and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_ctrl_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           i_srst,
    input  logic                           i_clr,
    input  logic                           i_wr,
    input  logic [WIDTH-1:0]               i_wdata,
    input  logic                           i_rd,
    output logic [WIDTH-1:0]               o_rdata,
    output logic                           o_full,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);
    localparam int unsigned c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [c_AW-1:0]  r_wptr_q, w_wptr_d;
    logic [c_AW-1:0]  r_rptr_q, w_rptr_d;
    logic [c_CW-1:0]  r_count_q, w_count_d;
    logic             w_empty;
    logic             w_do_wr;
    logic             w_do_rd;

    function automatic logic [c_AW-1:0] ptr_inc(input logic [c_AW-1:0] ptr);
        return (ptr == c_AW'(DEPTH - 1)) ? '0 : ptr + c_AW'(1);
    endfunction

    assign w_empty = (r_count_q == '0);
    assign o_full  = (r_count_q == c_CW'(DEPTH));
    assign o_count = r_count_q;
    assign o_rdata = r_mem_q[r_rptr_q];

    // A read frees the head slot, so a write into a full FIFO is accepted alongside it.
    assign w_do_rd = i_rd & ~w_empty;
    assign w_do_wr = i_wr & (~o_full | w_do_rd);

    always_comb begin
        w_wptr_d  = r_wptr_q;
        w_rptr_d  = r_rptr_q;
        w_count_d = r_count_q;
        if (w_do_wr) begin
            w_wptr_d = ptr_inc(r_wptr_q);
        end
        if (w_do_rd) begin
            w_rptr_d = ptr_inc(r_rptr_q);
        end
        case ({w_do_wr, w_do_rd})
            2'b10:   w_count_d = r_count_q + c_CW'(1);
            2'b01:   w_count_d = r_count_q - c_CW'(1);
            default: w_count_d = r_count_q;
        endcase
        if (i_clr) begin
            w_wptr_d  = '0;
            w_rptr_d  = '0;
            w_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
            r_count_q <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr && !i_clr) begin
            r_mem_q[r_wptr_q] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_stream_ctrl
// Description : Sequences a non-stallable pipelined FIR: issues samples, tracks
//               result latency, buffers results behind a credit counter, and
//               handles flush and clear. Define FIR_CTRL_STATS_EN to add the
//               o_cnt_in / o_cnt_out sample and result counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_stream_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned WW_INPUT   = 8,
    parameter int unsigned WW_OUTPUT  = 8,
    parameter int unsigned N_TAPS     = c_N_TAPS_DEFAULT,
    parameter int unsigned FIR_LAT    = c_FIR_LAT_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 i_srst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WW_INPUT-1:0]  s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WW_OUTPUT-1:0] m_data,
    output logic                 fir_en,
    output logic                 fir_srst,
    output logic [WW_INPUT-1:0]  fir_data,
    input  logic [WW_OUTPUT-1:0] fir_result,
    input  logic                 i_flush,
    input  logic                 i_clear,
    output logic                 o_busy,
`ifdef FIR_CTRL_STATS_EN
    output logic [31:0]          o_cnt_in,
    output logic [31:0]          o_cnt_out,
`endif
    output logic                 o_flush_done
);
    localparam int unsigned          c_CRED_W     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned          c_FLUSH_W    = flush_cnt_width(N_TAPS);
    localparam logic [c_CRED_W-1:0]  c_CRED_FULL  = c_CRED_W'(FIFO_DEPTH);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_LAST = c_FLUSH_W'(N_TAPS - 2);

    ctrl_state_e                      r_state_q, w_state_d;
    logic [c_FLUSH_W-1:0]             r_flush_cnt_q, w_flush_cnt_d;
    logic [c_CRED_W-1:0]              r_credits_q, w_credits_d;
    logic [FIR_LAT-1:0]               r_vpipe_q, w_vpipe_d;
    logic                             r_flush_done_q, w_flush_done_d;

    logic                             w_has_credit;
    logic                             w_hs;
    logic                             w_flush_issue;
    logic                             w_issue;
    logic                             w_pop;
    logic                             w_fifo_wr;
    logic                             w_fifo_full;
    logic [$clog2(FIFO_DEPTH+1)-1:0]  w_fifo_count;
    logic [WW_OUTPUT-1:0]             w_fifo_head;

    // Credits count FIFO slots not yet claimed by an issued sample, so every
    // result in flight is guaranteed a slot even with m_ready held low.
    assign w_has_credit  = (r_credits_q != '0);
    assign s_ready       = ~i_srst & (r_state_q == ST_RUN) & w_has_credit;
    assign w_hs          = s_valid & s_ready;
    assign w_flush_issue = ~i_srst & (r_state_q == ST_FLUSH) & w_has_credit;
    assign w_issue       = w_hs | w_flush_issue;

    assign fir_en        = w_issue;
    assign fir_data      = w_hs ? s_data : '0;
    assign fir_srst      = i_srst | (r_state_q == ST_CLEAR);
    assign o_busy        = i_srst | (r_state_q != ST_RUN);
    assign o_flush_done  = r_flush_done_q;

    assign m_valid       = ~i_srst & (w_fifo_count != '0);
    assign m_data        = w_fifo_head;
    assign w_pop         = m_valid & m_ready;
    assign w_fifo_wr     = r_vpipe_q[FIR_LAT-1];

    fir_ctrl_fifo #(
        .WIDTH (WW_OUTPUT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_srst  (i_srst),
        .i_clr   (i_clear),
        .i_wr    (w_fifo_wr),
        .i_wdata (fir_result),
        .i_rd    (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_flush_cnt_d  = r_flush_cnt_q;
        w_flush_done_d = 1'b0;
        w_vpipe_d      = (r_vpipe_q << 1) | FIR_LAT'(w_issue);

        case ({w_issue, w_pop})
            2'b10:   w_credits_d = r_credits_q - c_CRED_W'(1);
            2'b01:   w_credits_d = r_credits_q + c_CRED_W'(1);
            default: w_credits_d = r_credits_q;
        endcase

        case (r_state_q)
            ST_CLEAR: begin
                w_state_d     = ST_RUN;
                w_flush_cnt_d = '0;
            end
            ST_RUN: begin
                if (i_flush) begin
                    w_state_d     = ST_FLUSH;
                    w_flush_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                if (w_flush_issue) begin
                    if (r_flush_cnt_q == c_FLUSH_LAST) begin
                        w_state_d     = ST_DRAIN;
                        w_flush_cnt_d = '0;
                    end else begin
                        w_flush_cnt_d = r_flush_cnt_q + c_FLUSH_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (r_vpipe_q == '0) begin
                    w_state_d      = ST_RUN;
                    w_flush_done_d = 1'b1;
                end
            end
            default: w_state_d = ST_CLEAR;
        endcase

        // Clear discards everything in flight; it overrides any flush activity.
        if (i_clear) begin
            w_state_d      = ST_CLEAR;
            w_flush_cnt_d  = '0;
            w_flush_done_d = 1'b0;
            w_vpipe_d      = '0;
            w_credits_d    = c_CRED_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_state_q      <= ST_CLEAR;
            r_flush_cnt_q  <= '0;
            r_credits_q    <= c_CRED_FULL;
            r_vpipe_q      <= '0;
            r_flush_done_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_flush_cnt_q  <= w_flush_cnt_d;
            r_credits_q    <= w_credits_d;
            r_vpipe_q      <= w_vpipe_d;
            r_flush_done_q <= w_flush_done_d;
        end
    end

`ifdef FIR_CTRL_STATS_EN
    logic [31:0] r_cnt_in_q, w_cnt_in_d;
    logic [31:0] r_cnt_out_q, w_cnt_out_d;

    always_comb begin
        w_cnt_in_d  = r_cnt_in_q + 32'(w_hs);
        w_cnt_out_d = r_cnt_out_q + 32'(w_pop);
        if (i_clear) begin
            w_cnt_in_d  = '0;
            w_cnt_out_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_cnt_in_q  <= '0;
            r_cnt_out_q <= '0;
        end else begin
            r_cnt_in_q  <= w_cnt_in_d;
            r_cnt_out_q <= w_cnt_out_d;
        end
    end

    assign o_cnt_in  = r_cnt_in_q;
    assign o_cnt_out = r_cnt_out_q;
`endif

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (i_srst)
        !(w_fifo_wr && w_fifo_full));

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fir_stream_ctrl
// Description : Self-checking bench for fir_stream_ctrl with a stub FIR datapath
//               and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_stream_ctrl;
    localparam int NT    = 15;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int M_CLEAR = 0, M_RUN = 1, M_FLUSH = 2, M_DRAIN = 3;

    logic       clk = 1'b0;
    logic       i_srst, s_valid, m_ready, i_flush, i_clear;
    logic [7:0] s_data;
    logic [7:0] fir_result = 8'd0;
    logic       s_ready, m_valid, fir_en, fir_srst, o_busy, o_flush_done;
    logic [7:0] m_data, fir_data;
`ifdef FIR_CTRL_STATS_EN
    logic [31:0] o_cnt_in, o_cnt_out;
`endif

    always #5 clk = ~clk;

    fir_stream_ctrl dut (
        .clk(clk), .i_srst(i_srst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .fir_en(fir_en), .fir_srst(fir_srst), .fir_data(fir_data), .fir_result(fir_result),
        .i_flush(i_flush), .i_clear(i_clear), .o_busy(o_busy),
`ifdef FIR_CTRL_STATS_EN
        .o_cnt_in(o_cnt_in), .o_cnt_out(o_cnt_out),
`endif
        .o_flush_done(o_flush_done)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Filter response used by both the datapath stub and the model: coefficient k+1, mod 256.
    function automatic logic [7:0] fir_y(input logic [7:0] x [NT]);
        int s = 0;
        for (int k = 0; k < NT; k++) s += (k + 1) * int'(x[k]);
        return s[7:0];
    endfunction

    // Datapath stub: result of a sample enabled in cycle t shows on fir_result in t+LAT.
    logic [7:0] env_x [NT];
    logic [7:0] env_d [LAT];
    always @(posedge clk) begin
        if (fir_srst) begin
            for (int k = 0; k < NT; k++) env_x[k] = 8'd0;
            for (int k = 0; k < LAT; k++) env_d[k] = 8'd0;
            fir_result <= 8'd0;
        end else begin
            for (int k = LAT - 1; k > 0; k--) env_d[k] = env_d[k-1];
            if (fir_en) begin
                for (int k = NT - 1; k > 0; k--) env_x[k] = env_x[k-1];
                env_x[0] = fir_data;
                env_d[0] = fir_y(env_x);
            end else begin
                env_d[0] = 8'hA5;
            end
            fir_result <= env_d[LAT-1];
        end
    end

    // Reference model: mode, outstanding results, in-flight list and FIFO contents.
    typedef struct { int c; logic [7:0] v; } inf_t;
    inf_t       inflight [$];
    logic [7:0] fq [$];
    logic [7:0] mx [NT];
    int         md = M_CLEAR;
    int         outst = 0;
    int         flush_left = 0;
    logic       m_done = 1'b0;
    int         m_cnt_in = 0, m_cnt_out = 0;
    logic       exp_ready, exp_en, exp_mv;
    logic [7:0] exp_data;

    always @(posedge clk) begin : model
        bit   was_empty;
        inf_t e;
        was_empty = (inflight.size() == 0);
        if (i_srst || i_clear) begin
            md = M_CLEAR; outst = 0; flush_left = 0; m_done = 1'b0;
            inflight.delete(); fq.delete();
            for (int k = 0; k < NT; k++) mx[k] = 8'd0;
            m_cnt_in = 0; m_cnt_out = 0;
        end else begin
            m_done = 1'b0;
            if (exp_mv && m_ready) begin
                void'(fq.pop_front()); outst--; m_cnt_out++;
            end
            if (inflight.size() > 0 && inflight[0].c == cyc - LAT) begin
                fq.push_back(inflight[0].v);
                void'(inflight.pop_front());
            end
            if (exp_en) begin
                for (int k = NT - 1; k > 0; k--) mx[k] = mx[k-1];
                mx[0] = exp_data;
                e.c = cyc; e.v = fir_y(mx);
                inflight.push_back(e);
                outst++;
                if (md == M_RUN) m_cnt_in++;
            end
            case (md)
                M_CLEAR: md = M_RUN;
                M_RUN:   if (i_flush) begin md = M_FLUSH; flush_left = NT - 1; end
                M_FLUSH: if (exp_en) begin flush_left--; if (flush_left == 0) md = M_DRAIN; end
                default: if (was_empty) begin md = M_RUN; m_done = 1'b1; end
            endcase
        end
        cyc++;
    end

    // Per-cycle compare plus logging for the directed literal checks.
    logic [7:0] got [$];
    int done_cnt = 0;
    int en_mark = -1, mv_mark = -1;
    always @(negedge clk) begin
        exp_ready = (md == M_RUN) && (outst < DEPTH);
        exp_en    = ((md == M_RUN) && s_valid && exp_ready) || ((md == M_FLUSH) && (outst < DEPTH));
        exp_data  = ((md == M_RUN) && s_valid && exp_ready) ? s_data : 8'd0;
        exp_mv    = (fq.size() != 0);
        chk("s_ready", s_ready, exp_ready);
        chk("fir_en", fir_en, exp_en);
        chk("fir_data", fir_data, exp_data);
        chk("fir_srst", fir_srst, md == M_CLEAR);
        chk("o_busy", o_busy, md != M_RUN);
        chk("m_valid", m_valid, exp_mv);
        if (exp_mv) chk("m_data", m_data, fq[0]);
        chk("o_flush_done", o_flush_done, m_done);
`ifdef FIR_CTRL_STATS_EN
        chk("o_cnt_in", o_cnt_in, m_cnt_in);
        chk("o_cnt_out", o_cnt_out, m_cnt_out);
`endif
        if (m_valid === 1'b1 && m_ready) got.push_back(m_data);
        if (o_flush_done === 1'b1) done_cnt++;
        if (fir_en === 1'b1 && en_mark < 0) en_mark = cyc;
        if (m_valid === 1'b1 && mv_mark < 0) mv_mark = cyc;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_got(input int n, input int lim, input string name);
        int k = 0;
        while (got.size() < n && k < lim) begin step(1); k++; end
        chk(name, got.size(), n);
    endtask

    initial begin
        int acc, k;
        i_srst = 1'b1; s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b1;
        i_flush = 1'b0; i_clear = 1'b0;
        step(2);
        chk("rst_fir_srst", fir_srst, 1); chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", o_busy, 1); chk("rst_m_valid", m_valid, 0);
        step(1);
        i_srst = 1'b0;
        chk("rel_clear_cycle", fir_srst, 1); chk("rel_not_ready", s_ready, 0);
        step(1);
        chk("rel_srst_drop", fir_srst, 0); chk("rel_ready", s_ready, 1);

        // Three back-to-back samples.
        got.delete(); en_mark = -1; mv_mark = -1;
        for (int v = 1; v <= 3; v++) begin s_valid = 1'b1; s_data = 8'(v); step(1); end
        s_valid = 1'b0;
        wait_got(3, 20, "b2b_count");
        if (got.size() == 3) begin
            chk("b2b_r0", got[0], 1); chk("b2b_r1", got[1], 4); chk("b2b_r2", got[2], 10);
        end
        chk("b2b_latency", mv_mark - en_mark, LAT + 1);

        // Back-pressure: only FIFO_DEPTH samples are accepted.
        got.delete(); m_ready = 1'b0; acc = 0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = 8'(10 + i);
            if (s_ready) acc++;
            step(1);
        end
        s_valid = 1'b0;
        chk("bp_accepted", acc, DEPTH);
        m_ready = 1'b1;
        chk("bp_ready_at_pop", s_ready, 0);
        step(1);
        chk("bp_ready_after_pop", s_ready, 1);
        wait_got(DEPTH, 20, "bp_delivered");

        // Flush after a 127 impulse issued in the same cycle as the flush request.
        i_clear = 1'b1; step(1); i_clear = 1'b0; step(1);
        got.delete(); done_cnt = 0;
        s_valid = 1'b1; s_data = 8'd127; i_flush = 1'b1; step(1);
        s_valid = 1'b0; i_flush = 1'b0;
        chk("fl_ready_low", s_ready, 0); chk("fl_busy", o_busy, 1);
        wait_got(NT, 80, "fl_results");
        step(3);
        if (got.size() == NT) begin
            chk("fl_r0", got[0], 127); chk("fl_r1", got[1], 254);
            chk("fl_r2", got[2], 125); chk("fl_r14", got[14], 113);
        end
        chk("fl_done_pulses", done_cnt, 1); chk("fl_back_run", o_busy, 0);

        // Clear with two results in the FIFO and two in flight.
        got.delete(); m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin s_valid = 1'b1; s_data = 8'(20 + i); step(1); end
        s_valid = 1'b0; step(1);
        chk("clr_pre_valid", m_valid, 1);
        i_clear = 1'b1; step(1); i_clear = 1'b0;
        chk("clr_m_valid", m_valid, 0); chk("clr_srst", fir_srst, 1);
        m_ready = 1'b1; step(10);
        chk("clr_none_out", got.size(), 0); chk("clr_ready", s_ready, 1);

        // Handshake and pop together with one credit left.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin s_valid = 1'b1; s_data = 8'(40 + i); step(1); end
        s_valid = 1'b0; step(4);
        s_valid = 1'b1; s_data = 8'd55; m_ready = 1'b1;
        chk("sim_ready_one_credit", s_ready, 1);
        step(1);
        s_valid = 1'b0; m_ready = 1'b0;
        chk("sim_credit_kept", s_ready, 1);
        s_valid = 1'b1; s_data = 8'd56; step(1); s_valid = 1'b0;
        chk("sim_credit_used", s_ready, 0);
        m_ready = 1'b1; step(10);

        // Flush and clear together: clear wins.
        done_cnt = 0;
        i_flush = 1'b1; i_clear = 1'b1; step(1); i_flush = 1'b0; i_clear = 1'b0;
        chk("fc_clear_taken", fir_srst, 1);
        step(25);
        chk("fc_no_done", done_cnt, 0); chk("fc_run", o_busy, 0);

`ifdef FIR_CTRL_STATS_EN
        i_clear = 1'b1; step(1); i_clear = 1'b0;
        chk("st_in_zero", o_cnt_in, 0); chk("st_out_zero", o_cnt_out, 0);
        step(1);
        acc = 0; k = 0; s_valid = 1'b1;
        while (acc < 10 && k < 40) begin s_data = 8'(acc + 1); if (s_ready) acc++; step(1); k++; end
        s_valid = 1'b0; step(10);
        chk("st_in_10", o_cnt_in, 10); chk("st_out_10", o_cnt_out, 10);
        i_clear = 1'b1; step(1); i_clear = 1'b0; step(1);
        chk("st_in_cleared", o_cnt_in, 0); chk("st_out_cleared", o_cnt_out, 0);
`endif

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
